regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Writeback scheduler for the 32×32 register file: it shares the file's single write port (`we3`/`rd`/`wd3`) among `NREQ` writeback requesters using round-robin arbitration. It also keeps a per-register busy scoreboard: decode reserves a destination at issue, and the reservation is released when the write commits. The block sits between the execution/load units and `regfile`. Decode/hazard logic reads its `busy` vector.

## Interface
- `NREQ`, default 3: number of writeback requesters, 2..4.
- `clk` input 1: clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: requester i has a write pending.
- `req_ready` output NREQ: one-hot grant; a handshake is `req_valid[i] && req_ready[i]`.
- `req_rd` input 5·NREQ: destination of requester i, in bits [5i+4:5i].
- `req_data` input 32·NREQ: write data of requester i, in bits [32i+31:32i].
- `alloc_valid` input 1: decode requests a reservation of `alloc_rd`.
- `alloc_rd` input 5: register to reserve.
- `alloc_ready` output 1: reservation accepted this cycle.
- `flush` input 1: synchronous pipeline flush.
- `busy` output 32: scoreboard; `busy[r]`=1 means register r has an outstanding write. `busy[0]` is always 0.
- `we3` output 1: regfile write enable, registered.
- `rd` output 5: regfile write address, registered.
- `wd3` output 32: regfile write data, registered.

## Operation
- **Arbiter:**
  - Round-robin pointer `ptr` (0..NREQ-1) gives the highest-priority index.
  - Grant goes to the first i with `req_valid[i]`, searching `ptr`, `ptr+1`, … modulo NREQ.
  - `req_ready` is combinational from `req_valid`, `ptr` and `flush`, and at most one bit is set.
  - With `flush`=1, `req_ready` is all zero.
  - On a handshake, `ptr` ← grantee+1 (mod NREQ). With no handshake, `ptr` holds.
- **Write register:**
  - Each edge loads `we3` ← handshake && granted rd≠0.
  - On a handshake, `rd`/`wd3` load the granted `rd`/`data`. Otherwise they hold.
  - A handshake to x0 is consumed with `we3`=0.
- **Scoreboard:**
  - `alloc_ready` = `!flush && (alloc_rd==0 || !busy[alloc_rd])`.
  - An alloc handshake with `alloc_rd`≠0 sets that busy bit. Alloc of x0 is accepted and is a no-op.
  - A busy bit clears on the edge where the registered `we3`=1 for that `rd`, which is the same edge on which `regfile` commits the value. A consumer that sees `busy[r]`=0 therefore reads the new value.
  - Commit to a register that is not busy is legal; the clear is a no-op.
  - If set and clear hit different registers in the same cycle, both apply.
  - Set and clear cannot hit the same register in the same cycle: the bit is still 1 during the commit cycle, so `alloc_ready`=0.
- **Flush:**
  - Clears all busy bits at the next edge.
  - Blocks new grants and allocs.
  - A commit already registered (`we3`=1 in the flush cycle) still completes.
  - `ptr` is unchanged.

## Timing
- Reset values (asynchronous): `we3`=0, `rd`=0, `wd3`=0, `busy`=0, `ptr`=0.
  - `req_ready` and `alloc_ready` follow combinationally from the reset state.
  - Reset mid-operation drops the registered write and all reservations.
- Latency from handshake edge N:
  - `we3`/`rd`/`wd3` are valid during cycle N+1.
  - The regfile write and the `busy` clear happen at edge N+1.
- Throughput: one write per cycle; a continuously valid requester waits at most NREQ-1 cycles.
- Back-to-back handshakes to the same `rd` are legal. Ordering equals grant order.

## Structure
- Shared package `rv_regfile_pkg`:
  - `REG_ADDR_W`=5, `XLEN`=32, `NREGS`=32.
  - Constant `REG_ZERO`=5'd0.
- One sub-module `rr_arbiter` (parameter N): request, pointer → one-hot grant plus encoded index.
- Scoreboard, pointer and write register live in the top module.

## Test plan
- **Reset:** hold `resetn`=0 with random inputs → `we3`=0, `busy`=0, `ptr`=0. Release, then `req_valid`=3'b111 → `req_ready`=3'b001.
- **Round-robin:** all three requesters continuously valid with rd=1,2,3 → grants 0,1,2,0… and `we3` with `rd`=1,2,3,1… starting one cycle after the first grant.
- **Scoreboard hazard:**
  - alloc rd=5 → `busy[5]`=1, and a second alloc rd=5 sees `alloc_ready`=0.
  - Requester 1 writes rd=5, data=0xDEADBEEF → `we3`=1 the next cycle, `busy[5]`=0 after that edge, and regfile x5 reads 0xDEADBEEF in the same cycle.
- **x0:** alloc rd=0 → `alloc_ready`=1, `busy` unchanged. Write rd=0 data=0x1234 → handshake occurs, `we3` stays 0.
- **Flush:**
  - Busy bits 3 and 7 set, and `we3`=1 for rd=3 during the flush cycle → `req_ready`=0 and `alloc_ready`=0 that cycle; after the edge `busy`=0 and x3 is written.
- **Async reset mid-stream:** assert `resetn`=0 between edges while `we3`=1 → `we3` drops immediately, the regfile write is lost, and `busy`=0.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file constants for the writeback scheduler and its neighbours.
// Contents: address/data widths, register count, the x0 constant and a helper
// that turns a destination address into a scoreboard bit mask.
package rv_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NREGS      = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One-hot scoreboard mask for a register; x0 never maps to a bit.
  function automatic logic [NREGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
    logic [NREGS-1:0] m;
    m = '0;
    if (addr != REG_ZERO) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of writeback-request, reservation and regfile write-port signals.
// Ports: req_* (NREQ requesters), alloc_* (decode reservation), flush, busy,
// we3/rd/wd3 (regfile write port). slave = scheduler side, master = environment.
interface regfile_wb_scheduler_if #(
  parameter int NREQ = 3
);
  import rv_regfile_pkg::*;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [REG_ADDR_W*NREQ-1:0] req_rd;
  logic [XLEN*NREQ-1:0]       req_data;
  logic                       alloc_valid;
  logic [REG_ADDR_W-1:0]      alloc_rd;
  logic                       alloc_ready;
  logic                       flush;
  logic [NREGS-1:0]           busy;
  logic                       we3;
  logic [REG_ADDR_W-1:0]      rd;
  logic [XLEN-1:0]            wd3;

  modport slave (
    input  req_valid, req_rd, req_data, alloc_valid, alloc_rd, flush,
    output req_ready, alloc_ready, busy, we3, rd, wd3
  );

  modport master (
    output req_valid, req_rd, req_data, alloc_valid, alloc_rd, flush,
    input  req_ready, alloc_ready, busy, we3, rd, wd3
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: purely combinational, first requester at or after ptr wins.
// Ports: req (request vector), ptr (highest-priority index) -> grant (one-hot),
// idx (encoded winner), any (some request granted).
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin share of the regfile write port plus busy scoreboard.
// Ports: clk, resetn (async active-low), bus (slave modport: requests, allocs,
// flush, busy, registered we3/rd/wd3 one cycle after the grant edge).
module regfile_wb_scheduler #(
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  regfile_wb_scheduler_if.slave  bus
);
  import rv_regfile_pkg::*;

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]         ptr;
  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         gidx;
  logic                  hs;
  logic [REG_ADDR_W-1:0] g_rd;
  logic [XLEN-1:0]       g_data;
  logic [NREGS-1:0]      busy_q;
  logic                  we3_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       wd3_q;
  logic                  alloc_ok;
  logic [NREGS-1:0]      set_mask;
  logic [NREGS-1:0]      clr_mask;

  // Flush masks the requests so no grant (and no pointer move) can happen.
  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (bus.req_valid & {NREQ{!bus.flush}}),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (hs)
  );

  assign bus.req_ready = grant;

  always_comb begin
    g_rd   = bus.req_rd[gidx*REG_ADDR_W +: REG_ADDR_W];
    g_data = bus.req_data[gidx*XLEN +: XLEN];
  end

  // x0 is always reservable; any other register only when not already pending.
  assign alloc_ok        = !bus.flush && (bus.alloc_rd == REG_ZERO || !busy_q[bus.alloc_rd]);
  assign bus.alloc_ready = alloc_ok;

  // The clear follows the registered write, so it lands on the regfile commit edge.
  assign set_mask = (bus.alloc_valid && alloc_ok) ? reg_mask(bus.alloc_rd) : '0;
  assign clr_mask = we3_q ? reg_mask(rd_q) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we3_q <= 1'b0;
      rd_q  <= '0;
      wd3_q <= '0;
    end else begin
      // A write to x0 still consumes the grant but never pulses the enable.
      we3_q <= hs && (g_rd != REG_ZERO);
      if (hs) begin
        rd_q  <= g_rd;
        wd3_q <= g_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else if (bus.flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  assign bus.busy = busy_q;
  assign bus.we3  = we3_q;
  assign bus.rd   = rd_q;
  assign bus.wd3  = wd3_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a behavioural regfile on the write port.
// Ports: none; drives the master side of the interface, checks after each edge.
module tb_regfile_wb_scheduler;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;
  logic [31:0] rf [32];

  regfile_wb_scheduler_if #(.NREQ(3)) bus ();

  regfile_wb_scheduler #(.NREQ(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register file: commits on the edge where we3 is high.
  always @(posedge clk) begin
    if (bus.we3 && bus.rd != 5'd0) rf[bus.rd] <= bus.wd3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    // Reset held with random inputs.
    resetn          = 1'b0;
    bus.req_valid   = 3'($urandom);
    bus.req_rd      = 15'($urandom);
    bus.req_data    = {$urandom, $urandom, $urandom};
    bus.alloc_valid = 1'($urandom);
    bus.alloc_rd    = 5'($urandom);
    bus.flush       = 1'($urandom);
    repeat (3) tick();
    chk("rst_we3",  32'(bus.we3),  32'h0);
    chk("rst_busy", bus.busy,      32'h0);
    chk("rst_rd",   32'(bus.rd),   32'h0);
    chk("rst_wd3",  bus.wd3,       32'h0);

    // Release with all three requesters valid, rd = 1,2,3.
    bus.req_valid   = 3'b111;
    bus.req_rd      = {5'd3, 5'd2, 5'd1};
    bus.req_data    = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = 5'd0;
    bus.flush       = 1'b0;
    resetn          = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'h1);

    // Round-robin rotation.
    tick();
    chk("rr1_ready", 32'(bus.req_ready), 32'h2);
    chk("rr1_we3",   32'(bus.we3), 32'h1);
    chk("rr1_rd",    32'(bus.rd),  32'd1);
    chk("rr1_wd3",   bus.wd3,      32'h100);
    tick();
    chk("rr2_ready", 32'(bus.req_ready), 32'h4);
    chk("rr2_rd",    32'(bus.rd),  32'd2);
    tick();
    chk("rr3_ready", 32'(bus.req_ready), 32'h1);
    chk("rr3_rd",    32'(bus.rd),  32'd3);
    tick();
    chk("rr4_ready", 32'(bus.req_ready), 32'h2);
    chk("rr4_rd",    32'(bus.rd),  32'd1);
    chk("rr4_busy",  bus.busy,     32'h0);
    bus.req_valid = 3'b000;
    tick();
    chk("rr_idle_we3", 32'(bus.we3), 32'h0);

    // Scoreboard hazard on x5 (pointer now at 1).
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd5;
    #1;
    chk("sb_alloc_rdy", 32'(bus.alloc_ready), 32'h1);
    tick();
    chk("sb_busy5",      bus.busy, 32'h0000_0020);
    chk("sb_alloc_blk",  32'(bus.alloc_ready), 32'h0);
    bus.alloc_valid = 1'b0;
    bus.req_valid   = 3'b010;
    bus.req_rd      = {5'd0, 5'd5, 5'd0};
    bus.req_data    = {32'h0, 32'hDEAD_BEEF, 32'h0};
    #1;
    chk("sb_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 3'b000;
    #1;
    chk("sb_we3",       32'(bus.we3), 32'h1);
    chk("sb_rd",        32'(bus.rd),  32'd5);
    chk("sb_wd3",       bus.wd3,      32'hDEAD_BEEF);
    chk("sb_busy_hold", bus.busy,     32'h0000_0020);
    chk("sb_commit_blk", 32'(bus.alloc_ready), 32'h0);
    tick();
    chk("sb_busy_clr", bus.busy, 32'h0);
    chk("sb_rf5",      rf[5],    32'hDEAD_BEEF);
    chk("sb_we3_off",  32'(bus.we3), 32'h0);
    chk("sb_alloc_ok", 32'(bus.alloc_ready), 32'h1);

    // x0 alloc and write (pointer now at 2).
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd0;
    #1;
    chk("x0_alloc_rdy", 32'(bus.alloc_ready), 32'h1);
    tick();
    chk("x0_busy", bus.busy, 32'h0);
    bus.alloc_valid = 1'b0;
    bus.req_valid   = 3'b100;
    bus.req_rd      = {5'd0, 5'd0, 5'd0};
    bus.req_data    = {32'h0000_1234, 32'h0, 32'h0};
    #1;
    chk("x0_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 3'b000;
    #1;
    chk("x0_we3", 32'(bus.we3), 32'h0);
    chk("x0_wd3", bus.wd3,      32'h0000_1234);

    // Flush with x3/x7 reserved and a commit to x3 in flight (pointer now at 0).
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd3;
    tick();
    bus.alloc_rd    = 5'd7;
    tick();
    bus.alloc_valid = 1'b0;
    chk("fl_busy_pre", bus.busy, 32'h0000_0088);
    bus.req_valid = 3'b001;
    bus.req_rd    = {5'd0, 5'd0, 5'd3};
    bus.req_data  = {32'h0, 32'h0, 32'h0000_0033};
    #1;
    chk("fl_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid   = 3'b111;
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd9;
    #1;
    chk("fl_we3",     32'(bus.we3), 32'h1);
    chk("fl_rd",      32'(bus.rd),  32'd3);
    chk("fl_ready",   32'(bus.req_ready), 32'h0);
    chk("fl_alloc",   32'(bus.alloc_ready), 32'h0);
    chk("fl_busy_in", bus.busy, 32'h0000_0088);
    tick();
    bus.flush       = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.req_valid   = 3'b000;
    #1;
    chk("fl_busy_post", bus.busy, 32'h0);
    chk("fl_rf3",       rf[3],    32'h0000_0033);
    chk("fl_we3_post",  32'(bus.we3), 32'h0);
    bus.req_valid = 3'b111;
    #1;
    chk("fl_ptr_kept", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 3'b000;

    // Asynchronous reset while a write to x4 is registered (pointer at 1).
    bus.req_valid   = 3'b010;
    bus.req_rd      = {5'd0, 5'd4, 5'd0};
    bus.req_data    = {32'h0, 32'h0000_0044, 32'h0};
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd4;
    #1;
    chk("ar_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid   = 3'b000;
    bus.alloc_valid = 1'b0;
    #1;
    chk("ar_we3_pre",  32'(bus.we3), 32'h1);
    chk("ar_busy_pre", bus.busy,     32'h0000_0010);
    resetn = 1'b0;
    #1;
    chk("ar_we3",  32'(bus.we3), 32'h0);
    chk("ar_busy", bus.busy,     32'h0);
    chk("ar_rd",   32'(bus.rd),  32'h0);
    tick();
    chk("ar_rf4_lost", rf[4], 32'h0);
    resetn        = 1'b1;
    bus.req_valid = 3'b111;
    #1;
    chk("ar_ptr_rst", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
